// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl -- multi-cycle DIV/DIVU sequencer for the execute stage.
//
// Radix-2 restoring shift-subtract divider. Operands are captured as
// magnitudes when the instruction is first seen in IDLE; the iteration then
// produces one quotient bit per cycle while stall_req holds F/D/E. The final
// quotient/remainder is sign-corrected and offered to HI/LO with a single
// write strobe (hilo_we) on the cycle the E stage is allowed to advance.
//
// Optional feature macro: DIV_EARLY_EXIT_EN
//   When defined, a nonzero divisor whose magnitude exceeds the dividend's
//   magnitude skips the iteration and goes straight to DONE (quotient 0,
//   remainder = dividend). Undefined: every nonzero divisor runs WIDTH cycles.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous reset, active low
//   start         DIV/DIVU present in E (held high while stalled)
//   signed_div    1 = DIV (two's complement), 0 = DIVU
//   annul         flush/cancel, aborts any operation
//   advance       E stage may move this cycle
//   opa, opb      dividend (rs), divisor (rt)
//   stall_req     hold F/D/E
//   busy          sequencer not idle
//   result_valid  hi_out/lo_out hold the final result
//   hilo_we       write HI/LO this cycle
//   hi_out        remainder
//   lo_out        quotient
//   div_zero      current result came from a zero divisor
// -----------------------------------------------------------------------------
module div_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_div,
   input  logic             annul,
   input  logic             advance,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   output logic             stall_req,
   output logic             busy,
   output logic             result_valid,
   output logic             hilo_we,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             div_zero
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, ZERO, CALC, DONE} state_t;

   state_t           state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvs;
   logic             sign_q;
   logic             sign_r;

   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] rem_nxt;
   logic [WIDTH-1:0] quo_nxt;

   // Magnitude of an operand; unsigned operands pass through unchanged.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             is_signed);
      magnitude = (is_signed && v[WIDTH-1]) ? -v : v;
   endfunction

   // Final sign correction; wraps at WIDTH bits so -2^(W-1)/-1 needs no trap.
   function automatic logic [WIDTH-1:0] sign_fix(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
      sign_fix = neg ? -v : v;
   endfunction

   assign abs_a = magnitude(opa, signed_div);
   assign abs_b = magnitude(opb, signed_div);

   // One restoring step: shift {rem,quo} left, try subtracting the divisor.
   // The shifted partial remainder can reach WIDTH+1 bits, so the trial is
   // done one bit wider and its top bit is the borrow.
   always_comb begin
      shifted = {rem, quo[WIDTH-1]};
      trial   = shifted - {1'b0, dvs};
      if (!trial[WIDTH]) begin
         rem_nxt = trial[WIDTH-1:0];
         quo_nxt = {quo[WIDTH-2:0], 1'b1};
      end else begin
         rem_nxt = shifted[WIDTH-1:0];
         quo_nxt = {quo[WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         count        <= '0;
         rem          <= '0;
         quo          <= '0;
         dvs          <= '0;
         sign_q       <= 1'b0;
         sign_r       <= 1'b0;
         result_valid <= 1'b0;
         hi_out       <= '0;
         lo_out       <= '0;
         div_zero     <= 1'b0;
      end else if (annul) begin
         state        <= IDLE;
         result_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sign_q <= signed_div & (opa[WIDTH-1] ^ opb[WIDTH-1]);
                  sign_r <= signed_div & opa[WIDTH-1];
                  dvs    <= abs_b;
                  count  <= '0;
                  rem    <= '0;
                  if (opb == '0) begin
                     // Zero divisor reports the raw dividend, so keep it as-is.
                     quo   <= opa;
                     state <= ZERO;
                  end
`ifdef DIV_EARLY_EXIT_EN
                  else if (abs_a < abs_b) begin
                     quo          <= '0;
                     rem          <= abs_a;
                     lo_out       <= '0;
                     hi_out       <= sign_fix(abs_a, signed_div & opa[WIDTH-1]);
                     div_zero     <= 1'b0;
                     result_valid <= 1'b1;
                     state        <= DONE;
                  end
`endif
                  else begin
                     quo   <= abs_a;
                     state <= CALC;
                  end
               end
            end
            ZERO: begin
               lo_out       <= '1;
               hi_out       <= quo;
               div_zero     <= 1'b1;
               result_valid <= 1'b1;
               state        <= DONE;
            end
            CALC: begin
               rem   <= rem_nxt;
               quo   <= quo_nxt;
               count <= count + CW'(1);
               if (count == CW'(WIDTH - 1)) begin
                  lo_out       <= sign_fix(quo_nxt, sign_q);
                  hi_out       <= sign_fix(rem_nxt, sign_r);
                  div_zero     <= 1'b0;
                  result_valid <= 1'b1;
                  state        <= DONE;
               end
            end
            DONE: begin
               if (advance) begin
                  result_valid <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Stall is combinational so the pipeline is already held in the cycle the
   // instruction is first seen in IDLE. Gated by rst so reset forces it low.
   assign stall_req = rst & start & ~annul & (state != DONE);
   assign busy      = (state != IDLE);
   assign hilo_we   = result_valid & advance & ~annul;

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;

   localparam int W = 32;
`ifdef DIV_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic         clk;
   logic         rst;
   logic         start;
   logic         signed_div;
   logic         annul;
   logic         advance;
   logic [W-1:0] opa;
   logic [W-1:0] opb;
   logic         stall_req;
   logic         busy;
   logic         result_valid;
   logic         hilo_we;
   logic [W-1:0] hi_out;
   logic [W-1:0] lo_out;
   logic         div_zero;

   int total = 0;
   int bad   = 0;

   div_ctrl #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .signed_div   (signed_div),
      .annul        (annul),
      .advance      (advance),
      .opa          (opa),
      .opb          (opb),
      .stall_req    (stall_req),
      .busy         (busy),
      .result_valid (result_valid),
      .hilo_we      (hilo_we),
      .hi_out       (hi_out),
      .lo_out       (lo_out),
      .div_zero     (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
      end
   endtask

   // Reference: plain integer division. Signed case uses 64-bit arithmetic so
   // the most-negative / -1 case wraps instead of overflowing.
   function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sgn, output logic [W-1:0] lo,
                                   output logic [W-1:0] hi, output logic z,
                                   output int lat);
      longint sa, sb, q, r, ma, mb;
      z = 1'b0;
      if (b == 0) begin
         lo = '1; hi = a; z = 1'b1; lat = 2;
      end else if (!sgn) begin
         lo = a / b; hi = a % b;
         lat = (EARLY && (a < b)) ? 1 : W + 1;
      end else begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q = sa / sb; r = sa % sb;
         lo = W'(q); hi = W'(r);
         ma = (sa < 0) ? -sa : sa;
         mb = (sb < 0) ? -sb : sb;
         lat = (EARLY && (ma < mb)) ? 1 : W + 1;
      end
   endfunction

   // Behavioural model: phase 0 idle, 1 waiting out the latency, 2 result held.
   int           m_phase = 0;
   int           m_cnt   = 0;
   logic [W-1:0] m_lo    = '0;
   logic [W-1:0] m_hi    = '0;
   logic         m_z     = 1'b0;
   logic [W-1:0] p_lo    = '0;
   logic [W-1:0] p_hi    = '0;
   logic         p_z     = 1'b0;

   always @(posedge clk or negedge rst) begin : model
      logic [W-1:0] tl, th;
      logic         tz;
      int           tlat;
      if (!rst) begin
         m_phase <= 0; m_cnt <= 0;
         m_lo <= '0; m_hi <= '0; m_z <= 1'b0;
      end else if (annul) begin
         m_phase <= 0;
      end else begin
         case (m_phase)
            0: if (start) begin
               ref_div(opa, opb, signed_div, tl, th, tz, tlat);
               if (tlat == 1) begin
                  m_phase <= 2; m_lo <= tl; m_hi <= th; m_z <= tz;
               end else begin
                  m_phase <= 1; m_cnt <= tlat - 1;
                  p_lo <= tl; p_hi <= th; p_z <= tz;
               end
            end
            1: begin
               m_cnt <= m_cnt - 1;
               if (m_cnt == 1) begin
                  m_phase <= 2; m_lo <= p_lo; m_hi <= p_hi; m_z <= p_z;
               end
            end
            default: if (advance) m_phase <= 0;
         endcase
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("stall_req", W'(stall_req),
          W'(rst & start & ~annul & (m_phase != 2)));
      chk("busy", W'(busy), W'(m_phase != 0));
      chk("result_valid", W'(result_valid), W'(m_phase == 2));
      chk("hilo_we", W'(hilo_we), W'((m_phase == 2) & advance & ~annul));
      chk("hi_out", hi_out, m_hi);
      chk("lo_out", lo_out, m_lo);
      chk("div_zero", W'(div_zero), W'(m_z));
   end

   // Issue one operation starting just after a rising edge; returns the
   // cycle index at which result_valid appeared. Leaves start low, idle.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sgn, input int adv_wait, output int lat);
      opa = a; opb = b; signed_div = sgn; start = 1'b1; advance = 1'b0;
      @(posedge clk); #1;
      lat = 1;
      opa = $urandom; opb = $urandom;  // must be ignored after capture
      while (result_valid !== 1'b1 && lat < 64) begin
         @(posedge clk); #1;
         lat++;
      end
      if (lat >= 64) begin
         total++; bad++;
         $display("FAIL done_timeout actual=none required=result_valid");
      end
      repeat (adv_wait) begin
         @(posedge clk); #1;
      end
      advance = 1'b1;
      @(posedge clk); #1;
      advance = 1'b0; start = 1'b0;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int lat;
      logic [W-1:0] a, b, hold_lo, hold_hi;
      rst = 1'b0; start = 1'b0; signed_div = 1'b0; annul = 1'b0; advance = 1'b0;
      opa = '0; opb = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_lo", lo_out, 32'h0);
      chk("rst_hi", hi_out, 32'h0);
      chk("rst_busy", W'(busy), 32'h0);
      rst = 1'b1;
      @(posedge clk); #1;

      // DIVU 100/7
      do_op(32'd100, 32'd7, 1'b0, 0, lat);
      chk("divu_lat", lat, 32'd33);
      chk("divu_lo", lo_out, 32'd14);
      chk("divu_hi", hi_out, 32'd2);

      // DIV -7/2
      do_op(32'hFFFFFFF9, 32'd2, 1'b1, 1, lat);
      chk("div_neg_lo", lo_out, 32'hFFFFFFFD);
      chk("div_neg_hi", hi_out, 32'hFFFFFFFF);

      // DIV most-negative / -1 wraps
      do_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 0, lat);
      chk("div_ovf_lo", lo_out, 32'h80000000);
      chk("div_ovf_hi", hi_out, 32'h0);

      // DIVU 5/0
      do_op(32'd5, 32'd0, 1'b0, 0, lat);
      chk("dz_lat", lat, 32'd2);
      chk("dz_flag", W'(div_zero), 32'd1);
      chk("dz_lo", lo_out, 32'hFFFFFFFF);
      chk("dz_hi", hi_out, 32'd5);

      // Annul in the middle of the iteration
      opa = 32'd100; opb = 32'd7; signed_div = 1'b0; start = 1'b1;
      repeat (11) begin
         @(posedge clk); #1;
      end
      annul = 1'b1; start = 1'b0;
      #1;
      chk("annul_stall", W'(stall_req), 32'd0);
      chk("annul_we", W'(hilo_we), 32'd0);
      @(posedge clk); #1;
      annul = 1'b0;
      chk("annul_idle", W'(busy), 32'd0);
      do_op(32'd9, 32'd3, 1'b0, 0, lat);
      chk("post_annul_lo", lo_out, 32'd3);
      chk("post_annul_hi", hi_out, 32'd0);

      // Hold in DONE for 4 cycles with advance low
      opa = 32'd1000; opb = 32'd33; signed_div = 1'b0; start = 1'b1;
      repeat (33) begin
         @(posedge clk); #1;
      end
      hold_lo = lo_out; hold_hi = hi_out;
      chk("hold_lo_val", hold_lo, 32'd30);
      chk("hold_hi_val", hold_hi, 32'd10);
      repeat (4) begin
         chk("hold_valid", W'(result_valid), 32'd1);
         chk("hold_we", W'(hilo_we), 32'd0);
         chk("hold_lo", lo_out, 32'd30);
         @(posedge clk); #1;
      end
      advance = 1'b1;
      #1;
      chk("hold_release_we", W'(hilo_we), 32'd1);
      @(posedge clk); #1;
      advance = 1'b0; start = 1'b0;
      chk("hold_after_we", W'(hilo_we), 32'd0);
      chk("hold_after_busy", W'(busy), 32'd0);

      // Reset in the middle of the iteration
      opa = 32'd12345; opb = 32'd17; signed_div = 1'b0; start = 1'b1;
      repeat (8) begin
         @(posedge clk); #1;
      end
      #2;
      rst = 1'b0; start = 1'b0;
      #1;
      chk("mid_rst_busy", W'(busy), 32'd0);
      chk("mid_rst_lo", lo_out, 32'd0);
      chk("mid_rst_hi", hi_out, 32'd0);
      chk("mid_rst_stall", W'(stall_req), 32'd0);
      chk("mid_rst_valid", W'(result_valid), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      do_op(32'd3, 32'd10, 1'b0, 0, lat);
      chk("post_rst_lat", lat, EARLY ? 32'd1 : 32'd33);
      chk("post_rst_lo", lo_out, 32'd0);
      chk("post_rst_hi", hi_out, 32'd3);

      // Randomized operations, checked every cycle against the model
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 7))
            0: begin a = $urandom; b = '0; end
            1: begin a = $urandom_range(0, 20); b = $urandom_range(1, 40); end
            2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            3: begin a = -($urandom_range(0, 20)); b = $urandom_range(1, 40); end
            default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
         endcase
         do_op(a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 3), lat);
         @(posedge clk); #1;
      end

      repeat (2) @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
